// File: rtl/hamming74_serial_encoder.sv
// -----------------------------------------------------------------------------
// hamming74_serial_encoder
//
// Buffers 4-bit nibbles in a small FIFO, encodes each into a Hamming(7,4)
// codeword {p1,p2,d1,p3,d2,d3,d4} and shifts it out one bit per enabled cycle,
// codeword position 1 first. Frames follow each other with no gap while data
// is queued and ena stays high.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   ena          serializer advance enable (FIFO keeps accepting when low)
//   in_valid     in_data is valid
//   in_data[3:0] nibble, bit 0 = d1 .. bit 3 = d4
//   in_ready     FIFO can accept a nibble (decoded from the registered count)
//   enc_out      serial code bit (IDLE_BIT when no bit is sent)
//   enc_valid    enc_out carries a code bit this cycle
//   frame_start  first bit of a codeword
//   busy         codeword in flight or FIFO non-empty
// -----------------------------------------------------------------------------
module hamming74_serial_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter bit IDLE_BIT   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       enc_out,
  output logic       enc_valid,
  output logic       frame_start,
  output logic       busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // idx is the position of the NEXT bit to present; 7 means the last bit of
  // the current codeword is on the output and the frame ends at the next
  // enabled edge.
  localparam logic [2:0] IDX_DONE = 3'd7;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {p1, p2, d[0], p3, d[1], d[2], d[3]};
  endfunction

  // ---------------------------------------------------------------- FIFO
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_d;
  logic          push, pop;

  assign in_ready = (count < CW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign count_d  = count + CW'(push) - CW'(pop);

  // NOTE: the storage array carries no reset; validity is tracked by count,
  // so resetting the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;   // power-of-two depth: wraps naturally
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
    end
  end

  // ---------------------------------------------------------- serializer
  state_t     state, state_d;
  logic [2:0] idx, idx_d;
  logic [6:0] cw, cw_d, head_cw;
  logic       valid_d, out_d, fs_d, busy_d;

  assign head_cw = encode(mem[rd_ptr]);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cw_d    = cw;
    pop     = 1'b0;
    valid_d = 1'b0;
    out_d   = IDLE_BIT;
    fs_d    = 1'b0;

    if (ena) begin
      if (state == IDLE || idx == IDX_DONE) begin
        if (count != '0) begin
          // Load the next codeword and present its first bit right away.
          pop     = 1'b1;
          cw_d    = head_cw;
          state_d = SHIFT;
          idx_d   = 3'd1;
          valid_d = 1'b1;
          out_d   = head_cw[6];
          fs_d    = 1'b1;
        end else begin
          state_d = IDLE;
          idx_d   = 3'd0;
        end
      end else begin
        valid_d = 1'b1;
        out_d   = cw[3'd6 - idx];
        idx_d   = idx + 3'd1;
      end
    end

    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= 3'd0;
      cw          <= '0;
      enc_valid   <= 1'b0;
      enc_out     <= IDLE_BIT;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      cw          <= cw_d;
      enc_valid   <= valid_d;
      enc_out     <= out_d;
      frame_start <= fs_d;
      busy        <= busy_d;
    end
  end

endmodule
